// File: rtl/ebus_arb_pkg.sv
// Shared ebox definitions: EBUS width, requester indices and arbiter state encoding.
package ebus_arb_pkg;

    localparam int EBUS_W = 36;
    localparam int DRV_W  = 2;

    localparam int EDP = 0;
    localparam int IR  = 1;
    localparam int SCD = 2;
    localparam int APR = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } ebus_state_t;

endpackage

// File: rtl/ebus_arb_rr_pick.sv
// Round-robin picker: searches from (last+1) mod NREQ upward and returns the first set request.
// Purely combinational; win is all zeros when no request is set.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   idx
);

    // Scan farthest-first so the nearest candidate after 'last' overrides.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NREQ]) begin
                win                            = '0;
                win[(int'(last) + k) % NREQ]   = 1'b1;
                idx                            = IW'((int'(last) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/ebus_arb.sv
// EBUS arbiter: round-robin grant, drive/timeout tracking, one dead RELEASE cycle per tenure.
// Grant is registered one cycle after req; ebusTimeout/ebusConflict are registered one-cycle pulses.
module ebus_arb
    import ebus_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TMO  = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          drivingEBUS,
    input  logic [NREQ*EBUS_W-1:0]   ebusIn,
    output logic [NREQ-1:0]          grant,
    output logic [0:EBUS_W-1]        EBUS,
    output logic [DRV_W-1:0]         ebusDriver,
    output logic                     ebusBusy,
    output logic                     ebusTimeout,
    output logic                     ebusConflict
);

    localparam int CW = $clog2(TMO + 1);

    ebus_state_t       state, state_nxt;
    logic [NREQ-1:0]   grant_nxt;
    logic [DRV_W-1:0]  driver_nxt;
    logic [DRV_W-1:0]  last, last_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              tmo_nxt;
    logic              conflict_nxt;
    logic              drv_sel;
    logic [NREQ-1:0]   pick_win;
    logic [DRV_W-1:0]  pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (DRV_W)
    ) u_pick (
        .req  (req),
        .last (last),
        .win  (pick_win),
        .idx  (pick_idx)
    );

    assign drv_sel      = drivingEBUS[ebusDriver];
    assign ebusBusy     = (state != ST_IDLE);
    assign conflict_nxt = |(drivingEBUS & ~grant);

    // Bus is only ever the owner's word while it is both granted and driving; zero otherwise.
    always_comb begin
        EBUS = '0;
        if (grant[ebusDriver] && drv_sel) begin
            EBUS = ebusIn[int'(ebusDriver)*EBUS_W +: EBUS_W];
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        driver_nxt = ebusDriver;
        last_nxt   = last;
        cnt_nxt    = cnt;
        tmo_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt  = ST_GRANT;
                    grant_nxt  = pick_win;
                    driver_nxt = pick_idx;
                    last_nxt   = pick_idx;
                    cnt_nxt    = '0;
                end
            end
            ST_GRANT: begin
                // A dropped req does not end the tenure; only a drive or the timeout does.
                if (drv_sel) begin
                    state_nxt = ST_XFER;
                end else if (cnt == CW'(TMO - 1)) begin
                    tmo_nxt   = 1'b1;
                    grant_nxt = '0;
                    state_nxt = ST_RELEASE;
                end else if (cnt != CW'(TMO)) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_XFER: begin
                if (!drv_sel) begin
                    grant_nxt = '0;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                grant_nxt = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            grant        <= '0;
            ebusDriver   <= '0;
            last         <= DRV_W'(NREQ - 1);
            cnt          <= '0;
            ebusTimeout  <= 1'b0;
            ebusConflict <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            ebusDriver   <= driver_nxt;
            last         <= last_nxt;
            cnt          <= cnt_nxt;
            ebusTimeout  <= tmo_nxt;
            ebusConflict <= conflict_nxt;
        end
    end

endmodule

// File: tb/tb_ebus_arb.sv
// Directed bench for ebus_arb: reset, single transfer, round-robin, timeout, conflict, mid-transfer reset, lone requester.
module tb_ebus_arb;
    import ebus_arb_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = '0;
    logic [3:0]   drv = '0;
    logic [143:0] ebus_in = '0;
    logic [3:0]   grant;
    logic [35:0]  ebus_out;
    logic [1:0]   driver;
    logic         busy;
    logic         tmo;
    logic         conflict;

    int checks = 0;
    int errors = 0;

    logic [35:0] wd [4];

    always #5 clk = ~clk;

    ebus_arb #(.NREQ(4), .TMO(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .drivingEBUS  (drv),
        .ebusIn       (ebus_in),
        .grant        (grant),
        .EBUS         (ebus_out),
        .ebusDriver   (driver),
        .ebusBusy     (busy),
        .ebusTimeout  (tmo),
        .ebusConflict (conflict)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req = '0; drv = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; drv = 4'b0101;
        @(posedge clk); #2;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (driver !== 2'd0) begin errors++; $display("FAIL reset_driver got %0d want 0", driver); end
        checks++; if (tmo !== 1'b0 || conflict !== 1'b0) begin errors++; $display("FAIL reset_pulses got tmo=%b conflict=%b want 0 0", tmo, conflict); end
        checks++; if (ebus_out !== 36'o0) begin errors++; $display("FAIL reset_ebus got %o want 0", ebus_out); end
        reset = 1'b0; req = '0; drv = '0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        @(posedge clk); #1; drv = 4'b0001; #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_c1_grant got %b want 0001", grant); end
        checks++; if (driver !== 2'(EDP) || busy !== 1'b1) begin errors++; $display("FAIL single_c1_state got drv=%0d busy=%b want 0 1", driver, busy); end
        checks++; if (ebus_out !== 36'o123456765432) begin errors++; $display("FAIL single_c1_ebus got %o want 123456765432", ebus_out); end
        @(posedge clk); #2;
        checks++; if (grant !== 4'b0001 || ebus_out !== 36'o123456765432) begin errors++; $display("FAIL single_c2 got grant=%b ebus=%o want 0001 123456765432", grant, ebus_out); end
        @(posedge clk); #1; drv = '0; req = '0; #1;
        checks++; if (grant !== 4'b0001 || ebus_out !== 36'o0) begin errors++; $display("FAIL single_c3 got grant=%b ebus=%o want 0001 0", grant, ebus_out); end
        @(posedge clk); #2;
        checks++; if (grant !== 4'b0000 || busy !== 1'b1 || ebus_out !== 36'o0) begin errors++; $display("FAIL single_release got grant=%b busy=%b ebus=%o want 0000 1 0", grant, busy, ebus_out); end
        @(posedge clk); #2;
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL single_idle got busy=%b grant=%b want 0 0000", busy, grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        int k;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            k = ((c - 1) / 4) % 4;
            exp_g = (c % 4 == 1 || c % 4 == 2) ? 4'(1 << k) : 4'b0000;
            drv = (c % 4 == 1) ? exp_g : 4'b0000;
            #1;
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant cycle %0d got %b want %b", c, grant, exp_g); end
            if (c % 4 == 1) begin
                checks++; if (ebus_out !== wd[k]) begin errors++; $display("FAIL rr_ebus cycle %0d got %o want %o", c, ebus_out, wd[k]); end
            end
        end
        req = '0; drv = '0;
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        do_reset();
        req = 4'b0100;
        @(posedge clk); #1; req = 4'b1101; #1;
        checks++; if (grant !== 4'(1 << SCD)) begin errors++; $display("FAIL tmo_first_grant got %b want 0100", grant); end
        for (int c = 2; c <= 15; c++) begin
            @(posedge clk); #2;
            if (tmo === 1'b1) pulses++;
            checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL tmo_hold cycle %0d got %b want 0100", c, grant); end
        end
        @(posedge clk); #2;
        if (tmo === 1'b1) pulses++;
        checks++; if (tmo !== 1'b1 || grant !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL tmo_pulse got tmo=%b grant=%b busy=%b want 1 0000 1", tmo, grant, busy); end
        @(posedge clk); #2;
        if (tmo === 1'b1) pulses++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got busy=%b want 0", busy); end
        @(posedge clk); #2;
        checks++; if (grant !== 4'(1 << APR) || driver !== 2'(APR)) begin errors++; $display("FAIL tmo_next_grant got grant=%b drv=%0d want 1000 3", grant, driver); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL tmo_pulse_count got %0d want 1", pulses); end
        req = '0;
    endtask

    task automatic test_conflict();
        do_reset();
        req = 4'b0001;
        @(posedge clk); #1; drv = 4'b0011; #1;
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL conf_c1 got %b want 0", conflict); end
        checks++; if (ebus_out !== wd[EDP]) begin errors++; $display("FAIL conf_c1_ebus got %o want %o", ebus_out, wd[EDP]); end
        for (int c = 2; c <= 3; c++) begin
            @(posedge clk); #2;
            checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL conf_pulse cycle %0d got %b want 1", c, conflict); end
            checks++; if (ebus_out !== wd[EDP]) begin errors++; $display("FAIL conf_ebus cycle %0d got %o want %o", c, ebus_out, wd[EDP]); end
        end
        @(posedge clk); #1; drv = '0; req = '0; #1;
        checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL conf_c4 got %b want 1", conflict); end
        @(posedge clk); #2;
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL conf_clear got %b want 0", conflict); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001;
        @(posedge clk); #1; drv = 4'b0001; #1;
        @(posedge clk); #1; reset = 1'b1; #1;
        checks++; if (ebus_out !== wd[EDP]) begin errors++; $display("FAIL rmid_xfer_ebus got %o want %o", ebus_out, wd[EDP]); end
        @(posedge clk); #2;
        checks++; if (grant !== 4'b0000 || ebus_out !== 36'o0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_after got grant=%b ebus=%o busy=%b want 0000 0 0", grant, ebus_out, busy); end
        reset = 1'b0; req = 4'b1000; drv = '0;
        @(posedge clk); #2;
        checks++; if (grant !== 4'b1000 || driver !== 2'd3) begin errors++; $display("FAIL rmid_regrant got grant=%b drv=%0d want 1000 3", grant, driver); end
        req = '0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            exp_g = (c % 4 == 1 || c % 4 == 2) ? 4'(1 << IR) : 4'b0000;
            drv = (c % 4 == 1) ? 4'b0010 : 4'b0000;
            #1;
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL b2b_grant cycle %0d got %b want %b", c, grant, exp_g); end
            checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL b2b_timeout cycle %0d got %b want 0", c, tmo); end
            if (c % 4 == 3) begin
                checks++; if (busy !== 1'b1 || ebus_out !== 36'o0) begin errors++; $display("FAIL b2b_release cycle %0d got busy=%b ebus=%o want 1 0", c, busy, ebus_out); end
            end
        end
        req = '0; drv = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        wd[0] = 36'o123456765432;
        wd[1] = 36'o707070707070;
        wd[2] = 36'o000000000777;
        wd[3] = 36'o777000000001;
        ebus_in = {wd[3], wd[2], wd[1], wd[0]};
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_conflict();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ebus_arb.md
EBUS_ARB -- requirements
Module: ebus_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of EBUS requesters: index 0 EDP, 1 IR, 2 SCD, 3 APR.
REQ-002 The block SHALL have parameter TMO, default 15, giving the grant-to-drive timeout in cycles, range 1..255.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset. The ports are:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester EBUS request; level, held until done.
- drivingEBUS  in  NREQ  per-requester "my data is valid" strobe.
- ebusIn  in  NREQ*36  requester data; requester i occupies bits [36i+35:36i], each word in bit order 0:35.
- grant  out  NREQ  one-hot grant; registered.
- EBUS  out  36  bus word, bits 0:35.
- ebusDriver  out  2  index of the current bus owner.
- ebusBusy  out  1  FSM not in IDLE.
- ebusTimeout  out  1  one-cycle pulse when a grant is aborted.
- ebusConflict  out  1  one-cycle pulse when a non-granted requester asserts drivingEBUS.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, GRANT, XFER, RELEASE.
REQ-005 IDLE: when any req bit is set, the block SHALL pick a winner by round-robin, starting at (last+1) mod NREQ, where last is the most recent winner. It SHALL register grant[winner], set ebusDriver to the winner, and go to GRANT on the next edge.
REQ-006 Arbitration latency SHALL be exactly 1 cycle: req sampled in cycle N gives grant visible in cycle N+1.
REQ-007 GRANT: if drivingEBUS[winner]=1, the FSM SHALL go to XFER. If it is still 0 after TMO cycles in GRANT, the block SHALL pulse ebusTimeout, drop grant, and go to RELEASE.
REQ-008 XFER: the FSM SHALL stay in XFER while drivingEBUS[winner]=1. When drivingEBUS[winner] falls, it SHALL go to RELEASE and drop grant on that edge.
REQ-009 RELEASE SHALL last exactly one cycle, with grant=0 and EBUS=0, as a bus-turnaround dead cycle. It SHALL then go to IDLE.
REQ-010 EBUS SHALL be a combinational copy of ebusIn[winner] when grant[winner]=1 and drivingEBUS[winner]=1. Otherwise EBUS SHALL be all zeros; the bus never floats or ORs.
REQ-011 drivingEBUS[i]=1 with grant[i]=0 SHALL give a one-cycle ebusConflict pulse per offending cycle. The block SHALL ignore that requester's data.
REQ-012 A winner that drops req while in GRANT SHALL be treated as a timeout only when the TMO count expires. The block SHALL NOT end the grant early.
REQ-013 The last-winner pointer SHALL update only on entry to GRANT, so a timed-out requester still loses priority.
REQ-014 The timeout counter SHALL be ceil(log2(TMO+1)) bits wide, cleared on GRANT entry, and saturating, never wrapping.
REQ-015 A single requester SHALL be granted back to back with exactly one RELEASE cycle between tenures, giving a minimum of 4 cycles per transfer.
REQ-016 ebusBusy SHALL be 1 in GRANT, XFER and RELEASE, and 0 in IDLE.

Reset
REQ-017 On a reset edge, in any state, the block SHALL set: state IDLE, grant 0, ebusDriver 0, last pointer NREQ-1 (so requester 0 wins first), counter 0, ebusTimeout 0, ebusConflict 0.
REQ-018 Reset asserted during XFER SHALL force EBUS to 0 in the next cycle, whatever drivingEBUS is.

Structure
REQ-019 The state encoding, the requester index constants (EDP=0, IR=1, SCD=2, APR=3) and the EBUS width of 36 SHALL live in the shared ebox package.
REQ-020 The round-robin priority picker SHALL be one sub-module, rr_pick: NREQ request inputs plus a last pointer in, one-hot winner and index out, purely combinational.
REQ-021 The ebox top level SHALL replace its EBUS multiplexer with this block, wiring each sub-block's drivingEBUS and EBUS outputs to the matching req, drivingEBUS and ebusIn slices.

Verification
REQ-022 Scenario, single transfer: after reset, req=0001, drivingEBUS[0] high for 2 cycles with data 0o123456765432 -> grant=0001 in cycle 1, EBUS=0o123456765432 during the drive cycles, then one RELEASE cycle with EBUS=0, then IDLE.
REQ-023 Scenario, round-robin: req=1111 held, each granted requester drives for 1 cycle -> grant order 0,1,2,3,0, with 4 cycles per grant.
REQ-024 Scenario, timeout: req=0100 with drivingEBUS never asserted, TMO=15 -> ebusTimeout pulses once 15 cycles after grant, then RELEASE, then the next arbitration skips index 2 if others are requesting.
REQ-025 Scenario, conflict: grant=0001 in XFER while drivingEBUS=0011 -> ebusConflict=1 each such cycle, and EBUS equals ebusIn[0] only.
REQ-026 Scenario, reset mid-transfer: reset in XFER -> next cycle grant=0, EBUS=0, ebusBusy=0; then req=1000 -> requester 3 granted 1 cycle later.
REQ-027 Scenario, lone requester: req=0010 held continuously with 1-cycle drives -> grants separated by exactly one RELEASE cycle, and ebusTimeout never asserts.
